control_write_control: RTL

//  Writer end of the control-path packet centralized buffer (PCB): takes one free bufid per packet,

---
 rtl/control_write_control_pkg.sv | 30 +++
 rtl/control_write_control.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/control_write_control_pkg.sv
// Shared definitions for the control-path PCB writer and reader:
// beat flag encodings, field widths and descriptor layout.
package control_write_control_pkg;

    localparam int DATA_W   = 134;
    localparam int BUFID_W  = 9;
    localparam int OFF_W    = 7;
    localparam int INPORT_W = 4;
    localparam int WADDR_W  = BUFID_W + OFF_W;
    localparam int DESC_W   = 14;

    localparam int FLAG_HI = 133;
    localparam int FLAG_LO = 132;

    localparam logic [1:0] FLAG_HEAD = 2'b01;
    localparam logic [1:0] FLAG_MID  = 2'b11;
    localparam logic [1:0] FLAG_TAIL = 2'b10;

    localparam logic [INPORT_W-1:0] INPORT_RSVD = 4'hf;
    localparam logic [OFF_W-1:0]    OFF_LAST    = 7'h7f;

    // Descriptor layout: {1'b0, inport, bufid}
    function automatic logic [DESC_W-1:0] make_desc(
        input logic [INPORT_W-1:0] inport,
        input logic [BUFID_W-1:0]  bufid
    );
        return {1'b0, inport, bufid};
    endfunction

endpackage

// File: rtl/control_write_control.sv
// Control-path PCB writer: claims a bufid, writes packet beats at
// {bufid,offset} and issues one descriptor per completed packet.
module control_write_control
    import control_write_control_pkg::*;
(
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic [133:0]        iv_pkt_data,
    input  logic [3:0]          iv_pkt_inport,
    input  logic                i_pkt_data_wr,
    output logic                o_pkt_data_ready,
    input  logic [8:0]          iv_pkt_bufid,
    input  logic                i_pkt_bufid_wr,
    output logic                o_pkt_bufid_ack,
    output logic [133:0]        ov_pkt,
    output logic [15:0]         ov_pkt_waddr,
    output logic                o_pkt_wr,
    input  logic                i_pkt_waddr_ack,
    output logic [13:0]         ov_pkt_descriptor,
    output logic                o_pkt_descriptor_wr,
    output logic [2:0]          pkt_write_state,
    output logic [15:0]         ov_debug_pkt_cnt,
    output logic [15:0]         ov_debug_err_cnt
);

    localparam logic [2:0] GET_BUFID_S = 3'd0;
    localparam logic [2:0] WAIT_HEAD_S = 3'd1;
    localparam logic [2:0] WAIT_ACK_S  = 3'd2;
    localparam logic [2:0] WRITE_S     = 3'd3;
    localparam logic [2:0] DESC_S      = 3'd4;
    localparam logic [2:0] DISCARD_S   = 3'd5;

    logic [2:0]          state_q,   state_d;
    logic                ready_q,   ready_d;
    logic                ack_q,     ack_d;
    logic [BUFID_W-1:0]  bufid_q,   bufid_d;
    logic [INPORT_W-1:0] inport_q,  inport_d;
    logic [OFF_W-1:0]    off_q,     off_d;
    logic                trunc_q,   trunc_d;
    logic [DATA_W-1:0]   pkt_q,     pkt_d;
    logic [WADDR_W-1:0]  waddr_q,   waddr_d;
    logic                wr_q,      wr_d;
    logic [DESC_W-1:0]   desc_q,    desc_d;
    logic                desc_wr_q, desc_wr_d;
    logic [15:0]         pcnt_q,    pcnt_d;
    logic [15:0]         ecnt_q,    ecnt_d;

    logic             accept;
    logic             is_head;
    logic             is_tail;
    logic             rsvd;
    logic             wr_go;
    logic             force_tail;
    logic             err_inc;
    logic [OFF_W-1:0] go_off;

    assign accept  = i_pkt_data_wr & ready_q;
    assign is_head = (iv_pkt_data[FLAG_HI:FLAG_LO] == FLAG_HEAD);
    assign is_tail = (iv_pkt_data[FLAG_HI:FLAG_LO] == FLAG_TAIL);
    assign rsvd    = (iv_pkt_inport == INPORT_RSVD);

    always_comb begin
        state_d    = state_q;
        ready_d    = ready_q;
        ack_d      = 1'b0;
        bufid_d    = bufid_q;
        inport_d   = inport_q;
        off_d      = off_q;
        trunc_d    = trunc_q;
        pkt_d      = pkt_q;
        waddr_d    = waddr_q;
        wr_d       = wr_q;
        desc_d     = desc_q;
        desc_wr_d  = 1'b0;
        pcnt_d     = pcnt_q;
        ecnt_d     = ecnt_q;
        wr_go      = 1'b0;
        force_tail = 1'b0;
        err_inc    = 1'b0;
        go_off     = '0;

        case (state_q)
            GET_BUFID_S: begin
                // Ack pulses while still in this state; move on the cycle after.
                if (ack_q) begin
                    ready_d = 1'b1;
                    state_d = WAIT_HEAD_S;
                end else if (i_pkt_bufid_wr) begin
                    bufid_d = iv_pkt_bufid;
                    ack_d   = 1'b1;
                end
            end
            WAIT_HEAD_S: begin
                if (accept) begin
                    if (!is_head) begin
                        err_inc = 1'b1;
                    end else if (rsvd) begin
                        err_inc = 1'b1;
                        state_d = DISCARD_S;
                    end else begin
                        inport_d = iv_pkt_inport;
                        wr_go    = 1'b1;
                    end
                end
            end
            WAIT_ACK_S: begin
                if (i_pkt_waddr_ack && wr_q) begin
                    wr_d  = 1'b0;
                    off_d = off_q + OFF_W'(1);
                    if (pkt_q[FLAG_HI:FLAG_LO] == FLAG_TAIL) begin
                        desc_d    = make_desc(inport_q, bufid_q);
                        desc_wr_d = 1'b1;
                        pcnt_d    = pcnt_q + 16'd1;
                        state_d   = DESC_S;
                    end else begin
                        ready_d = 1'b1;
                        state_d = WRITE_S;
                    end
                end
            end
            WRITE_S: begin
                if (accept) begin
                    if (is_head) begin
                        // Missing tail: restart the same bufid from offset 0.
                        err_inc = 1'b1;
                        if (rsvd) begin
                            state_d = DISCARD_S;
                        end else begin
                            inport_d = iv_pkt_inport;
                            wr_go    = 1'b1;
                        end
                    end else begin
                        go_off = off_q;
                        wr_go  = 1'b1;
                        if (off_q == OFF_LAST && !is_tail) begin
                            force_tail = 1'b1;
                            err_inc    = 1'b1;
                            trunc_d    = 1'b1;
                        end
                    end
                end
            end
            DESC_S: begin
                if (trunc_q) begin
                    ready_d = 1'b1;
                    state_d = DISCARD_S;
                end else begin
                    state_d = GET_BUFID_S;
                end
            end
            DISCARD_S: begin
                if (accept && is_tail) begin
                    if (trunc_q) begin
                        // Bufid already handed off with the descriptor.
                        trunc_d = 1'b0;
                        ready_d = 1'b0;
                        state_d = GET_BUFID_S;
                    end else begin
                        state_d = WAIT_HEAD_S;
                    end
                end
            end
            default: begin
                ready_d = 1'b0;
                wr_d    = 1'b0;
                state_d = GET_BUFID_S;
            end
        endcase

        if (wr_go) begin
            pkt_d = iv_pkt_data;
            if (force_tail) begin
                pkt_d[FLAG_HI:FLAG_LO] = FLAG_TAIL;
            end
            off_d   = go_off;
            waddr_d = {bufid_q, go_off};
            wr_d    = 1'b1;
            ready_d = 1'b0;
            state_d = WAIT_ACK_S;
        end

        if (err_inc) begin
            ecnt_d = ecnt_q + 16'd1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= GET_BUFID_S;
            ready_q   <= 1'b0;
            ack_q     <= 1'b0;
            bufid_q   <= '0;
            inport_q  <= '0;
            off_q     <= '0;
            trunc_q   <= 1'b0;
            pkt_q     <= '0;
            waddr_q   <= '0;
            wr_q      <= 1'b0;
            desc_q    <= '0;
            desc_wr_q <= 1'b0;
            pcnt_q    <= '0;
            ecnt_q    <= '0;
        end else begin
            state_q   <= state_d;
            ready_q   <= ready_d;
            ack_q     <= ack_d;
            bufid_q   <= bufid_d;
            inport_q  <= inport_d;
            off_q     <= off_d;
            trunc_q   <= trunc_d;
            pkt_q     <= pkt_d;
            waddr_q   <= waddr_d;
            wr_q      <= wr_d;
            desc_q    <= desc_d;
            desc_wr_q <= desc_wr_d;
            pcnt_q    <= pcnt_d;
            ecnt_q    <= ecnt_d;
        end
    end

    assign o_pkt_data_ready    = ready_q;
    assign o_pkt_bufid_ack     = ack_q;
    assign ov_pkt              = pkt_q;
    assign ov_pkt_waddr        = waddr_q;
    assign o_pkt_wr            = wr_q;
    assign ov_pkt_descriptor   = desc_q;
    assign o_pkt_descriptor_wr = desc_wr_q;
    assign pkt_write_state     = state_q;
    assign ov_debug_pkt_cnt    = pcnt_q;
    assign ov_debug_err_cnt    = ecnt_q;

endmodule
